// File: rtl/rob_pkg.sv
// Shared types for the superscalar reorder buffer: entry layout, field widths and tag-width helper.
package rob_pkg;

  localparam int ROB_XLEN      = 32;
  localparam int ROB_REG_IDX_W = 5;
  // Wide enough for a per-cycle dispatch or retire count of up to 4.
  localparam int CNT_W         = 3;

  typedef struct packed {
    logic                     valid;
    logic                     complete;
    logic                     is_branch;
    logic                     taken;
    logic [ROB_REG_IDX_W-1:0] dest_reg;
    logic [ROB_XLEN-1:0]      pc;
    logic [ROB_XLEN-1:0]      pred_npc;
    logic [ROB_XLEN-1:0]      target;
    logic [ROB_XLEN-1:0]      value;
  } rob_entry_t;

  function automatic int tag_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/rob_ptr.sv
// Wrap-bit circular pointer: clear, load, or advance by a variable amount each cycle.
module rob_ptr #(
  parameter int TAG_W = 5,
  parameter int ADV_W = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             ld,
  input  logic [TAG_W:0]   ld_val,
  input  logic [ADV_W-1:0] adv,
  output logic [TAG_W:0]   ptr,
  output logic [TAG_W:0]   ptr_nxt
);

  always_comb begin
    if (clr)
      ptr_nxt = '0;
    else if (ld)
      ptr_nxt = ld_val;
    else
      ptr_nxt = ptr + (TAG_W+1)'(adv);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      ptr <= '0;
    else
      ptr <= ptr_nxt;
  end

endmodule

// File: rtl/rob_superscalar.sv
// N-wide reorder buffer: in-order allocate/retire, out-of-order completion, flush on retire-time mispredict.
// Optional perf counters are enabled by defining ROB_PERF_CNT_EN.
module rob_superscalar
  import rob_pkg::*;
#(
  parameter int ROB_DEPTH      = 32,
  parameter int DISPATCH_WIDTH = 2,
  parameter int RETIRE_WIDTH   = 2,
  parameter int CDB_PORTS      = 2,
  parameter int XLEN           = ROB_XLEN,
  parameter int REG_IDX_W      = ROB_REG_IDX_W,
  localparam int TAG_W         = tag_w(ROB_DEPTH)
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              squash,
  input  logic [DISPATCH_WIDTH-1:0]         dp_valid,
  input  logic [DISPATCH_WIDTH*REG_IDX_W-1:0] dp_dest_reg,
  input  logic [DISPATCH_WIDTH*XLEN-1:0]    dp_pc,
  input  logic [DISPATCH_WIDTH*XLEN-1:0]    dp_pred_npc,
  input  logic [DISPATCH_WIDTH-1:0]         dp_is_branch,
  output logic                              dp_ready,
  output logic [DISPATCH_WIDTH*TAG_W-1:0]   dp_tag,
  input  logic [CDB_PORTS-1:0]              cdb_valid,
  input  logic [CDB_PORTS*TAG_W-1:0]        cdb_tag,
  input  logic [CDB_PORTS*XLEN-1:0]         cdb_value,
  input  logic [CDB_PORTS-1:0]              cdb_taken,
  input  logic [CDB_PORTS*XLEN-1:0]         cdb_target,
  output logic [RETIRE_WIDTH-1:0]           rt_valid,
  output logic [RETIRE_WIDTH*TAG_W-1:0]     rt_tag,
  output logic [RETIRE_WIDTH*REG_IDX_W-1:0] rt_dest_reg,
  output logic [RETIRE_WIDTH*XLEN-1:0]      rt_value,
  output logic                              flush,
  output logic [XLEN-1:0]                   flush_pc,
  output logic [TAG_W:0]                    free_count,
  output logic                              empty
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [63:0]                       perf_retired,
  output logic [31:0]                       perf_flushes
`endif
);

  localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(ROB_DEPTH);

  rob_entry_t       ent     [ROB_DEPTH];
  rob_entry_t       ent_nxt [ROB_DEPTH];
  logic [TAG_W:0]   head, tail, head_nxt, tail_nxt;
  logic [TAG_W-1:0] head_idx, tail_idx;
  logic [CNT_W-1:0] rt_cnt, dp_cnt, dp_adv;

  assign head_idx = head[TAG_W-1:0];
  assign tail_idx = tail[TAG_W-1:0];
  assign empty    = (head == tail);
  assign dp_ready = (free_count >= (TAG_W+1)'(DISPATCH_WIDTH));

  always_comb begin
    dp_tag = '0;
    dp_cnt = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      dp_tag[i*TAG_W +: TAG_W] = tail_idx + TAG_W'(i);
      dp_cnt = dp_cnt + CNT_W'(dp_valid[i]);
    end
  end

  // Retire window: stops at the first incomplete entry or just after a mispredicted branch.
  always_comb begin
    logic             ok;
    logic [TAG_W-1:0] idx;
    rob_entry_t       e;
    logic [XLEN-1:0]  npc;
    rt_valid    = '0;
    rt_tag      = '0;
    rt_dest_reg = '0;
    rt_value    = '0;
    flush       = 1'b0;
    flush_pc    = '0;
    rt_cnt      = '0;
    ok          = 1'b1;
    idx         = '0;
    e           = '0;
    npc         = '0;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      idx = head_idx + TAG_W'(i);
      e   = ent[idx];
      npc = e.taken ? e.target : e.pc + XLEN'(4);
      if (ok && e.valid && e.complete) begin
        rt_valid[i]                          = 1'b1;
        rt_tag[i*TAG_W +: TAG_W]             = idx;
        rt_dest_reg[i*REG_IDX_W +: REG_IDX_W] = e.dest_reg;
        rt_value[i*XLEN +: XLEN]             = e.value;
        rt_cnt                               = rt_cnt + CNT_W'(1);
        if (e.is_branch && (npc != e.pred_npc)) begin
          flush    = 1'b1;
          flush_pc = npc;
          ok       = 1'b0;
        end
      end else begin
        ok = 1'b0;
      end
    end
  end

  assign dp_adv = dp_ready ? dp_cnt : '0;

  rob_ptr #(.TAG_W(TAG_W), .ADV_W(CNT_W)) u_head (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (squash),
    .ld      (1'b0),
    .ld_val  ('0),
    .adv     (rt_cnt),
    .ptr     (head),
    .ptr_nxt (head_nxt)
  );

  // On a flush the tail collapses onto the advanced head, discarding all younger entries.
  rob_ptr #(.TAG_W(TAG_W), .ADV_W(CNT_W)) u_tail (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (squash),
    .ld      (flush),
    .ld_val  (head_nxt),
    .adv     (dp_adv),
    .ptr     (tail),
    .ptr_nxt (tail_nxt)
  );

  always_comb begin
    logic [TAG_W-1:0] idx;
    ent_nxt = ent;
    idx     = '0;
    if (squash || flush) begin
      for (int j = 0; j < ROB_DEPTH; j++)
        ent_nxt[j].valid = 1'b0;
    end else begin
      for (int i = 0; i < RETIRE_WIDTH; i++)
        if (rt_valid[i])
          ent_nxt[head_idx + TAG_W'(i)].valid = 1'b0;
      // Ascending port order lets the highest port win on a shared tag.
      for (int p = 0; p < CDB_PORTS; p++) begin
        idx = cdb_tag[p*TAG_W +: TAG_W];
        if (cdb_valid[p] && ent[idx].valid) begin
          ent_nxt[idx].complete = 1'b1;
          ent_nxt[idx].value    = cdb_value[p*XLEN +: XLEN];
          ent_nxt[idx].taken    = cdb_taken[p];
          ent_nxt[idx].target   = cdb_target[p*XLEN +: XLEN];
        end
      end
      if (dp_ready) begin
        for (int i = 0; i < DISPATCH_WIDTH; i++)
          if (dp_valid[i])
            ent_nxt[tail_idx + TAG_W'(i)] = '{
              valid:     1'b1,
              complete:  1'b0,
              is_branch: dp_is_branch[i],
              taken:     1'b0,
              dest_reg:  dp_dest_reg[i*REG_IDX_W +: REG_IDX_W],
              pc:        dp_pc[i*XLEN +: XLEN],
              pred_npc:  dp_pred_npc[i*XLEN +: XLEN],
              target:    '0,
              value:     '0
            };
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ent        <= '{default: '0};
      free_count <= DEPTH_C;
    end else begin
      ent        <= ent_nxt;
      free_count <= DEPTH_C - (tail_nxt - head_nxt);
    end
  end

`ifdef ROB_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_retired <= '0;
      perf_flushes <= '0;
    end else begin
      if (perf_retired > ({64{1'b1}} - 64'(rt_cnt)))
        perf_retired <= {64{1'b1}};
      else
        perf_retired <= perf_retired + 64'(rt_cnt);
      if (flush && (perf_flushes != {32{1'b1}}))
        perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rob_superscalar.sv
// Bench for rob_superscalar: queue-based program-order model checked every cycle, plus directed literal cases.
module tb_rob_superscalar;

  localparam int D  = 32;
  localparam int DW = 2;
  localparam int RW = 2;
  localparam int CP = 2;
  localparam int TW = 5;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             squash;
  logic [DW-1:0]    dp_valid, dp_is_branch;
  logic [DW*5-1:0]  dp_dest_reg;
  logic [DW*32-1:0] dp_pc, dp_pred_npc;
  logic             dp_ready;
  logic [DW*TW-1:0] dp_tag;
  logic [CP-1:0]    cdb_valid, cdb_taken;
  logic [CP*TW-1:0] cdb_tag;
  logic [CP*32-1:0] cdb_value, cdb_target;
  logic [RW-1:0]    rt_valid;
  logic [RW*TW-1:0] rt_tag;
  logic [RW*5-1:0]  rt_dest_reg;
  logic [RW*32-1:0] rt_value;
  logic             flush;
  logic [31:0]      flush_pc;
  logic [TW:0]      free_count;
  logic             empty;
`ifdef ROB_PERF_CNT_EN
  logic [63:0]      perf_retired;
  logic [31:0]      perf_flushes;
`endif

  rob_superscalar dut (
    .clock(clock), .reset_n(reset_n), .squash(squash),
    .dp_valid(dp_valid), .dp_dest_reg(dp_dest_reg), .dp_pc(dp_pc),
    .dp_pred_npc(dp_pred_npc), .dp_is_branch(dp_is_branch),
    .dp_ready(dp_ready), .dp_tag(dp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_taken(cdb_taken), .cdb_target(cdb_target),
    .rt_valid(rt_valid), .rt_tag(rt_tag), .rt_dest_reg(rt_dest_reg),
    .rt_value(rt_value), .flush(flush), .flush_pc(flush_pc),
    .free_count(free_count), .empty(empty)
`ifdef ROB_PERF_CNT_EN
    , .perf_retired(perf_retired), .perf_flushes(perf_flushes)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int          tag;
    logic [4:0]  dest;
    logic [31:0] pc, pred, val, tgt;
    bit          br, tk, done;
  } ent_t;

  ent_t q[$];
  int   head;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_in();
    squash = 0; dp_valid = '0; dp_is_branch = '0; dp_dest_reg = '0;
    dp_pc = '0; dp_pred_npc = '0; cdb_valid = '0; cdb_taken = '0;
    cdb_tag = '0; cdb_value = '0; cdb_target = '0;
  endtask

  task automatic set_dp(input int s, input logic [4:0] d, input logic [31:0] pc,
                        input logic [31:0] pred, input bit br);
    dp_valid[s] = 1'b1;
    dp_is_branch[s] = br;
    dp_dest_reg[s*5 +: 5] = d;
    dp_pc[s*32 +: 32] = pc;
    dp_pred_npc[s*32 +: 32] = pred;
  endtask

  task automatic set_cdb(input int p, input logic [4:0] t, input logic [31:0] v,
                         input bit tk, input logic [31:0] tg);
    cdb_valid[p] = 1'b1;
    cdb_tag[p*TW +: TW] = t;
    cdb_value[p*32 +: 32] = v;
    cdb_taken[p] = tk;
    cdb_target[p*32 +: 32] = tg;
  endtask

  // Compare outputs against the model for the current state, then advance the model over one edge.
  task automatic step();
    ent_t        e;
    int          n, tail_t;
    bit          ok, fl, rdy;
    logic [31:0] fpc, npc;
    logic [RW-1:0] ev;
    #1;
    ok = 1; n = 0; fl = 0; fpc = '0; ev = '0;
    for (int i = 0; i < RW; i++) begin
      if (ok && i < q.size() && q[i].done) begin
        ev[i] = 1'b1;
        n++;
        chk("rt_tag", rt_tag[i*TW +: TW], q[i].tag);
        chk("rt_dest", rt_dest_reg[i*5 +: 5], q[i].dest);
        chk("rt_value", rt_value[i*32 +: 32], q[i].val);
        npc = q[i].tk ? q[i].tgt : q[i].pc + 32'd4;
        if (q[i].br && npc != q[i].pred) begin
          fl = 1; fpc = npc; ok = 0;
        end
      end else ok = 0;
    end
    chk("rt_valid", rt_valid, ev);
    chk("flush", flush, fl);
    if (fl) chk("flush_pc", flush_pc, fpc);
    chk("free_count", free_count, D - q.size());
    chk("empty", empty, q.size() == 0);
    rdy = (D - q.size()) >= DW;
    chk("dp_ready", dp_ready, rdy);
    tail_t = (head + q.size()) % D;
    for (int i = 0; i < DW; i++) chk("dp_tag", dp_tag[i*TW +: TW], (tail_t + i) % D);

    if (squash) begin
      q.delete(); head = 0;
    end else if (fl) begin
      head = (head + n) % D; q.delete();
    end else begin
      for (int p = 0; p < CP; p++)
        if (cdb_valid[p])
          foreach (q[j])
            if (q[j].tag == int'(cdb_tag[p*TW +: TW])) begin
              q[j].done = 1; q[j].val = cdb_value[p*32 +: 32];
              q[j].tk = cdb_taken[p]; q[j].tgt = cdb_target[p*32 +: 32];
            end
      for (int k = 0; k < n; k++) void'(q.pop_front());
      head = (head + n) % D;
      if (rdy)
        for (int i = 0; i < DW; i++)
          if (dp_valid[i]) begin
            e.tag = (tail_t + i) % D; e.dest = dp_dest_reg[i*5 +: 5];
            e.pc = dp_pc[i*32 +: 32]; e.pred = dp_pred_npc[i*32 +: 32];
            e.br = dp_is_branch[i]; e.tk = 0; e.done = 0; e.val = '0; e.tgt = '0;
            q.push_back(e);
          end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  // Reset is asserted away from any clock edge so the outputs must go to reset values asynchronously.
  task automatic do_reset();
    reset_n = 0;
    clear_in();
    q.delete(); head = 0;
    #1;
    chk("rst_free_count", free_count, D);
    chk("rst_dp_ready", dp_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_rt_valid", rt_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_flush_pc", flush_pc, 0);
`ifdef ROB_PERF_CNT_EN
    chk("rst_perf_retired", perf_retired, 0);
    chk("rst_perf_flushes", perf_flushes, 0);
`endif
    @(negedge clock);
    reset_n = 1;
  endtask

  initial begin
    logic [31:0] pc;
    int r;
    reset_n = 0;
    clear_in();
    @(negedge clock);
    do_reset();

    // Fill 2/cycle to full, then show dispatch is ignored when not ready
    for (int c = 0; c < 16; c++) begin
      clear_in();
      set_dp(0, 5'(2*c), 32'h1000 + 32'(16*c), 32'h1004 + 32'(16*c), 0);
      set_dp(1, 5'(2*c+1), 32'h1008 + 32'(16*c), 32'h100C + 32'(16*c), 0);
      chk("fill_dp_tag", dp_tag, (10'(2*c+1) << 5) | 10'(2*c));
      step();
    end
    chk("full_free_count", free_count, 0);
    chk("full_dp_ready", dp_ready, 0);
    step();
    chk("full_still_zero", free_count, 0);

    // Out-of-order completion: tag 1 first blocks until tag 0 completes
    clear_in(); set_cdb(0, 5'd1, 32'h11, 0, 0); step();
    clear_in(); step();
    chk("ooo_no_retire", rt_valid, 2'b00);
    set_cdb(1, 5'd0, 32'h10, 0, 0); step();
    clear_in();
    chk("ooo_rt_valid", rt_valid, 2'b11);
    chk("ooo_rt_tag", rt_tag, 10'h020);
    chk("ooo_rt_value", rt_value, 64'h00000011_00000010);
    step();
    chk("ooo_free_after", free_count, 2);

    // Mispredicted taken branch at tag 3
    do_reset();
    set_dp(0, 5'd1, 32'h0F0, 32'h0F4, 0); set_dp(1, 5'd2, 32'h0F4, 32'h0F8, 0); step();
    clear_in();
    set_dp(0, 5'd3, 32'h0F8, 32'h0FC, 0); set_dp(1, 5'd0, 32'h100, 32'h104, 1); step();
    clear_in(); set_cdb(0, 5'd0, 32'hA0, 0, 0); set_cdb(1, 5'd1, 32'hA1, 0, 0); step();
    clear_in(); set_cdb(0, 5'd2, 32'hA2, 0, 0); set_cdb(1, 5'd3, 32'hA3, 1, 32'h200); step();
    clear_in();
    chk("br_rt_valid", rt_valid, 2'b11);
    chk("br_rt_tag", rt_tag, 10'h062);
    chk("br_flush", flush, 1);
    chk("br_flush_pc", flush_pc, 32'h200);
    set_dp(0, 5'd7, 32'h300, 32'h304, 0); set_dp(1, 5'd8, 32'h304, 32'h308, 0);
    step();
    clear_in();
    chk("br_empty_after", empty, 1);
    chk("br_free_after", free_count, D);
    set_cdb(0, 5'd3, 32'hBAD, 0, 0); step();
    clear_in();
    chk("stale_cdb_rt_valid", rt_valid, 2'b00);
    chk("stale_cdb_empty", empty, 1);
    step();

    // Tail and head wrap: 30 through, then tags 30,31,0,1
    do_reset();
    for (int c = 0; c < 15; c++) begin
      clear_in();
      set_dp(0, 5'd4, 32'(8*c), 32'(8*c+4), 0); set_dp(1, 5'd5, 32'(8*c+4), 32'(8*c+8), 0);
      step();
    end
    for (int c = 0; c < 15; c++) begin
      clear_in();
      set_cdb(0, 5'(2*c), 32'(c), 0, 0); set_cdb(1, 5'(2*c+1), 32'(c+100), 0, 0);
      step();
    end
    clear_in();
    for (int c = 0; c < 40 && !empty; c++) step();
    chk("drain_empty", empty, 1);
    set_dp(0, 5'd9, 32'h40, 32'h44, 0); set_dp(1, 5'd10, 32'h44, 32'h48, 0);
    chk("wrap_dp_tag_a", dp_tag, 10'h3FE);
    step();
    clear_in();
    set_dp(0, 5'd11, 32'h48, 32'h4C, 0); set_dp(1, 5'd12, 32'h4C, 32'h50, 0);
    chk("wrap_dp_tag_b", dp_tag, 10'h020);
    set_cdb(0, 5'd30, 32'h30, 0, 0); set_cdb(1, 5'd31, 32'h31, 0, 0);
    step();
    clear_in();
    set_cdb(0, 5'd0, 32'h40, 0, 0); set_cdb(1, 5'd1, 32'h41, 0, 0);
    chk("wrap_rt_tag_a", rt_tag, 10'h3FE);
    chk("wrap_rt_valid_a", rt_valid, 2'b11);
    step();
    clear_in();
    chk("wrap_rt_tag_b", rt_tag, 10'h020);
    chk("wrap_rt_valid_b", rt_valid, 2'b11);
    step();
    chk("wrap_free_back", free_count, D);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      clear_in();
      r = $urandom_range(0, 3);
      for (int s = 0; s < DW; s++)
        if (r >= s + 1) begin
          pc = $urandom & 32'hFFFF_FFFC;
          set_dp(s, 5'($urandom), pc,
                 ($urandom_range(0, 1) == 1) ? pc + 32'd4 : ($urandom & 32'hFFFF_FFFC),
                 $urandom_range(0, 7) == 0);
        end
      for (int p = 0; p < CP; p++)
        if ($urandom_range(0, 1) == 1)
          set_cdb(p, (q.size() > 0 && $urandom_range(0, 4) != 0) ?
                     5'(q[$urandom_range(0, q.size()-1)].tag) : 5'($urandom),
                  $urandom, $urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC);
      squash = ($urandom_range(0, 199) == 0);
      step();
    end

    // Asynchronous reset with 10 entries in flight
    do_reset();
    for (int c = 0; c < 5; c++) begin
      clear_in();
      set_dp(0, 5'd1, 32'(c*8), 32'(c*8+4), 0); set_dp(1, 5'd2, 32'(c*8+4), 32'(c*8+8), 0);
      step();
    end
    chk("inflight_free", free_count, D - 10);
    do_reset();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
